// File: rtl/lp805x_schedfs_mc_if.sv
// Bundle between the SFR scaling registers and the scheduler.
// Ports: en_i, factor_i, load_i, [sync_i]; index_o, tick_o, pend_o.
interface lp805x_schedfs_mc_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic                      en_i;
   logic [CHANNELS*WIDTH-1:0] factor_i;
   logic [CHANNELS-1:0]       load_i;
`ifdef LP805X_SCHEDFS_SYNC_EN
   logic                      sync_i;
`endif
   logic [CHANNELS*WIDTH-1:0] index_o;
   logic [CHANNELS-1:0]       tick_o;
   logic [CHANNELS-1:0]       pend_o;

`ifdef LP805X_SCHEDFS_SYNC_EN
   modport master (
      output en_i, factor_i, load_i, sync_i,
      input  index_o, tick_o, pend_o
   );
   modport slave (
      input  en_i, factor_i, load_i, sync_i,
      output index_o, tick_o, pend_o
   );
`else
   modport master (
      output en_i, factor_i, load_i,
      input  index_o, tick_o, pend_o
   );
   modport slave (
      input  en_i, factor_i, load_i,
      output index_o, tick_o, pend_o
   );
`endif
endinterface

// File: rtl/lp805x_schedfs_mc.sv
// Multi-channel clock-enable scheduler: one tick per factor+1 cycles.
// Ports: clki, rstn, bus (slave). Option macro: LP805X_SCHEDFS_SYNC_EN.
module lp805x_schedfs_mc #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic                  clki,
   input logic                  rstn,
   lp805x_schedfs_mc_if.slave   bus
);
   logic [CHANNELS-1:0][WIDTH-1:0] idx_q;
   logic [CHANNELS-1:0]            tick_q;
   logic [CHANNELS-1:0]            pf_q;
   logic                           sync;

`ifdef LP805X_SCHEDFS_SYNC_EN
   assign sync = bus.sync_i;
`else
   assign sync = 1'b0;
`endif

   assign bus.index_o = idx_q;
   assign bus.tick_o  = tick_q;
   assign bus.pend_o  = pf_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [WIDTH-1:0] act;
      logic [WIDTH-1:0] pnd;
      logic [WIDTH-1:0] fac;
      logic             ld;

      assign fac = bus.factor_i[k*WIDTH +: WIDTH];
      assign ld  = bus.load_i[k];

      always_ff @(posedge clki or negedge rstn) begin
         if (!rstn) begin
            idx_q[k]  <= '0;
            act       <= '0;
            pnd       <= '0;
            pf_q[k]   <= 1'b0;
            tick_q[k] <= 1'b0;
         end else if (sync) begin
            // realign; a same-cycle load beats the pending value
            idx_q[k]  <= '0;
            tick_q[k] <= 1'b0;
            pf_q[k]   <= 1'b0;
            if (ld)
               act <= fac;
            else if (pf_q[k])
               act <= pnd;
         end else if (bus.en_i) begin
            if (idx_q[k] == act) begin
               idx_q[k]  <= '0;
               tick_q[k] <= 1'b1;
               pf_q[k]   <= 1'b0;
               if (ld)
                  act <= fac;
               else if (pf_q[k])
                  act <= pnd;
            end else begin
               idx_q[k]  <= idx_q[k] + WIDTH'(1);
               tick_q[k] <= 1'b0;
               // defer until wrap so the period stays whole
               if (ld) begin
                  pnd     <= fac;
                  pf_q[k] <= 1'b1;
               end
            end
         end else begin
            tick_q[k] <= 1'b0;
            if (ld) begin
               act     <= fac;
               pf_q[k] <= 1'b0;
               if (idx_q[k] > fac)
                  idx_q[k] <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_lp805x_schedfs_mc.sv
// Directed bench for lp805x_schedfs_mc: vector table plus corner sequences.
// Drives the bus interface, prints CHECKS/ERRORS summary.
module tb_lp805x_schedfs_mc;
   localparam int W = 8;
   localparam int C = 4;

   typedef struct {
      logic        en;
      logic [3:0]  load;
      logic [31:0] fac;
      logic [31:0] idx;
      logic [3:0]  tick;
      logic [3:0]  pend;
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];

   lp805x_schedfs_mc_if #(.WIDTH(W), .CHANNELS(C)) bus ();

   lp805x_schedfs_mc #(.WIDTH(W), .CHANNELS(C)) dut (
      .clki (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   task automatic add(input logic en, input logic ld, input int f,
                      input int i, input logic [3:0] t, input logic p);
      vec_t v;
      v.en   = en;
      v.load = {3'b000, ld};
      v.fac  = 32'(f & 8'hff);
      v.idx  = 32'(i);
      v.tick = t;
      v.pend = {3'b000, p};
      vq.push_back(v);
   endtask

   task automatic chk_all(input string nm, input logic [31:0] i,
                          input logic [3:0] t, input logic [3:0] p);
      chk({nm, "_idx"}, 64'(bus.index_o), 64'(i));
      chk({nm, "_tick"}, 64'(bus.tick_o), 64'(t));
      chk({nm, "_pend"}, 64'(bus.pend_o), 64'(p));
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] E = 4'b1110;
   localparam logic [3:0] A = 4'b1111;

   initial begin
      int n;
      int t0;
      int t1;
      int mx;
      bus.en_i     = 1'b0;
      bus.factor_i = '0;
      bus.load_i   = '0;
`ifdef LP805X_SCHEDFS_SYNC_EN
      bus.sync_i   = 1'b0;
`endif

      // table: channel 0 exercised, channels 1..3 idle at factor 0
      add(0, 1, 3, 0, 4'h0, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 0, 0, 2, E, 0);
      add(1, 0, 0, 3, E, 0);
      add(1, 0, 0, 0, A, 0);
      add(1, 0, 0, 1, E, 0);
      add(0, 1, 5, 1, 4'h0, 0);
      add(1, 1, 2, 2, E, 1);
      add(1, 0, 0, 3, E, 1);
      add(1, 0, 0, 4, E, 1);
      add(1, 0, 0, 5, E, 1);
      add(1, 0, 0, 0, A, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 0, 0, 2, E, 0);
      add(1, 0, 0, 0, A, 0);
      add(1, 0, 0, 1, E, 0);
      add(0, 1, 4, 1, 4'h0, 0);
      add(1, 0, 0, 2, E, 0);
      add(1, 0, 0, 3, E, 0);
      add(1, 0, 0, 4, E, 0);
      add(1, 1, 7, 0, A, 0);
      for (int i = 1; i <= 7; i++) add(1, 0, 0, i, E, 0);
      add(1, 0, 0, 0, A, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 0, 0, 2, E, 0);
      add(1, 0, 0, 3, E, 0);
      add(0, 1, 1, 0, 4'h0, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 0, 0, 0, A, 0);
      add(0, 0, 0, 0, 4'h0, 0);
      add(0, 1, 6, 0, 4'h0, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 1, 9, 2, E, 1);
      add(1, 1, 3, 3, E, 1);
      add(1, 0, 0, 4, E, 1);
      add(1, 0, 0, 5, E, 1);
      add(1, 0, 0, 6, E, 1);
      add(1, 0, 0, 0, A, 0);
      add(1, 0, 0, 1, E, 0);
      add(1, 0, 0, 2, E, 0);
      add(1, 0, 0, 3, E, 0);
      add(1, 0, 0, 0, A, 0);

      #1 rstn = 1'b0;
      #1 chk_all("rst_hold", 32'd0, 4'h0, 4'h0);
      #20 rstn = 1'b1;
      #1 chk_all("rst_rel", 32'd0, 4'h0, 4'h0);

      foreach (vq[i]) begin
         bus.en_i     = vq[i].en;
         bus.load_i   = vq[i].load;
         bus.factor_i = vq[i].fac;
         step();
         chk_all($sformatf("vec%0d", i), vq[i].idx, vq[i].tick,
                 vq[i].pend);
      end

      // reset mid-period with a pending load
      bus.en_i     = 1'b1;
      bus.load_i   = 4'b0001;
      bus.factor_i = 32'd2;
      step();
      bus.load_i   = '0;
      chk("midrst_pend", 64'(bus.pend_o), 64'h1);
      #3 rstn = 1'b0;
      #1 chk_all("async_rst", 32'd0, 4'h0, 4'h0);
      bus.en_i = 1'b0;
      step();
      chk_all("rst_held", 32'd0, 4'h0, 4'h0);
      #2 rstn = 1'b1;
      #1 chk_all("post_rel", 32'd0, 4'h0, 4'h0);
      bus.en_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all($sformatf("idle_f0_%0d", i), 32'd0, 4'hf, 4'h0);
      end

      // maximum factor on channel 2: period 2^WIDTH
      bus.en_i     = 1'b0;
      bus.load_i   = 4'b0100;
      bus.factor_i = 32'h00ff_0000;
      step();
      bus.load_i = '0;
      bus.en_i   = 1'b1;
      t0 = -1;
      t1 = -1;
      mx = 0;
      n  = 0;
      while (n < 600 && t1 < 0) begin
         step();
         n++;
         if (int'(bus.index_o[23:16]) > mx) mx = int'(bus.index_o[23:16]);
         if (bus.tick_o[2]) begin
            if (t0 < 0) t0 = n;
            else t1 = n;
         end
      end
      chk("max_first", 64'(t0), 64'd256);
      chk("max_period", 64'(t1 - t0), 64'd256);
      chk("max_index", 64'(mx), 64'd255);

`ifdef LP805X_SCHEDFS_SYNC_EN
      bus.en_i     = 1'b0;
      bus.load_i   = 4'b0011;
      bus.factor_i = 32'h0000_0502;
      step();
      bus.load_i = '0;
      bus.en_i   = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("pre_sync_idx", 64'(bus.index_o[15:0]), 64'h0401);
      bus.sync_i = 1'b1;
      step();
      bus.sync_i = 1'b0;
      chk("sync_idx", 64'(bus.index_o[15:0]), 64'h0);
      chk("sync_tick", 64'(bus.tick_o[1:0]), 64'h0);
      t0 = -1;
      t1 = -1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (bus.tick_o[0] && t0 < 0) t0 = i;
         if (bus.tick_o[1] && t1 < 0) t1 = i;
      end
      chk("sync_tick0", 64'(t0), 64'd3);
      chk("sync_tick1", 64'(t1), 64'd6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
